// File: rtl/execute_unit_pipe_if.sv
// Operand/control and result bundle for execute_unit_pipe.
// master issues operations and consumes results; slave is the execute unit.
interface execute_unit_pipe_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [XLEN-1:0] C;
  logic [XLEN-1:0] PC;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [1:0]      ALUOp;
  logic            ALUSrc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] ALU_result;
  logic [XLEN-1:0] Target;
  logic            Zero;
  logic            BranchTaken;
  logic            Illegal;

  modport master (
    output in_valid, A, B, C, PC, funct3, funct7, ALUOp, ALUSrc, out_ready,
    input  in_ready, out_valid, ALU_result, Target, Zero, BranchTaken, Illegal
  );

  modport slave (
    input  in_valid, A, B, C, PC, funct3, funct7, ALUOp, ALUSrc, out_ready,
    output in_ready, out_valid, ALU_result, Target, Zero, BranchTaken, Illegal
  );
endinterface

// File: rtl/execute_unit_pipe.sv
// Registered RV execute stage: ALU result, branch target and decision behind a valid/ready output register.
// Define EXEC_MUL_EN to build the iterative shift-add MUL (ALUOp=10, funct7=0000001, funct3=000).
module execute_unit_pipe #(
  parameter int XLEN = 64,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  execute_unit_pipe_if.slave bus
);

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {EMPTY, FULL, MUL} state_t;
`else
  typedef enum logic [1:0] {EMPTY, FULL} state_t;
`endif

  state_t state, next_state, load_state;

  logic [XLEN-1:0] op2, sum, diff, sra_res, res, target;
  logic [SHW-1:0]  shamt;
  logic            lt_s, lt_u, taken, illegal;
  logic            in_ready, out_valid, accept, load;

  logic [XLEN-1:0] result_q, target_q;
  logic            zero_q, taken_q, illegal_q;

`ifdef EXEC_MUL_EN
  logic [XLEN-1:0] mcand, mplier, acc, mul_sum;
  logic [SHW-1:0]  count;
  logic            is_mul, mul_start, mul_last;
`endif

  assign op2     = bus.ALUSrc ? bus.C : bus.B;
  assign shamt   = op2[SHW-1:0];
  assign sum     = bus.A + op2;
  assign diff    = bus.A - op2;
  assign sra_res = $signed(bus.A) >>> shamt;
  assign lt_s    = $signed(bus.A) < $signed(op2);
  assign lt_u    = bus.A < op2;
  assign target  = bus.PC + (bus.C << 1);

  always_comb begin
    res     = '0;
    taken   = 1'b0;
    illegal = 1'b0;
`ifdef EXEC_MUL_EN
    is_mul  = 1'b0;
`endif
    case (bus.ALUOp)
      2'b00: res = sum;
      2'b01: begin
        res = diff;
        case (bus.funct3)
          3'b000:  taken = (bus.A == op2);
          3'b001:  taken = (bus.A != op2);
          3'b100:  taken = lt_s;
          3'b101:  taken = !lt_s;
          3'b110:  taken = lt_u;
          3'b111:  taken = !lt_u;
          default: illegal = 1'b1;
        endcase
      end
      default: begin
        // funct7 legality only applies to R-type; I-type uses funct7[5] solely to pick srai
        if (bus.ALUOp == 2'b10 && bus.funct7 == 7'b0000001) begin
`ifdef EXEC_MUL_EN
          if (bus.funct3 == 3'b000) is_mul = 1'b1;
          else                      illegal = 1'b1;
`else
          illegal = 1'b1;
`endif
        end else if (bus.ALUOp == 2'b10 && bus.funct7 != 7'b0000000 &&
                     !(bus.funct7 == 7'b0100000 &&
                       (bus.funct3 == 3'b000 || bus.funct3 == 3'b101))) begin
          illegal = 1'b1;
        end else begin
          case (bus.funct3)
            3'b000:  res = (bus.ALUOp == 2'b10 && bus.funct7[5]) ? diff : sum;
            3'b001:  res = bus.A << shamt;
            3'b010:  res = {{(XLEN-1){1'b0}}, lt_s};
            3'b011:  res = {{(XLEN-1){1'b0}}, lt_u};
            3'b100:  res = bus.A ^ op2;
            3'b101:  res = bus.funct7[5] ? sra_res : (bus.A >> shamt);
            3'b110:  res = bus.A | op2;
            default: res = bus.A & op2;
          endcase
        end
      end
    endcase
  end

  assign accept = bus.in_valid && in_ready;

`ifdef EXEC_MUL_EN
  assign load       = accept && !flush && !is_mul;
  assign mul_start  = accept && !flush && is_mul;
  assign load_state = is_mul ? MUL : FULL;
`else
  assign load       = accept && !flush;
  assign load_state = FULL;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      EMPTY: if (accept) next_state = load_state;
      FULL:  if (bus.out_ready) next_state = accept ? load_state : EMPTY;
`ifdef EXEC_MUL_EN
      MUL:   if (mul_last) next_state = FULL;
`endif
      default: next_state = EMPTY;
    endcase
    if (flush) next_state = EMPTY;
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      EMPTY: in_ready = 1'b1;
      FULL: begin
        in_ready  = bus.out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Result registers change only on a load, so they stay frozen while FULL waits on out_ready
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q  <= '0;
      target_q  <= '0;
      zero_q    <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (load) begin
      result_q  <= res;
      target_q  <= target;
      zero_q    <= (res == '0);
      taken_q   <= taken;
      illegal_q <= illegal;
    end
`ifdef EXEC_MUL_EN
    else if (mul_start) begin
      target_q  <= target;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (state == MUL && mul_last && !flush) begin
      result_q  <= mul_sum;
      zero_q    <= (mul_sum == '0);
    end
`endif
  end

`ifdef EXEC_MUL_EN
  // One multiplier bit per cycle; the final partial sum goes straight into result_q
  assign mul_sum  = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (count == SHW'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (mul_start) begin
      mcand  <= bus.A;
      mplier <= op2;
      acc    <= '0;
      count  <= '0;
    end else if (state == MUL) begin
      acc    <= mul_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + SHW'(1);
    end
  end
`endif

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.ALU_result  = result_q;
  assign bus.Target      = target_q;
  assign bus.Zero        = zero_q;
  assign bus.BranchTaken = taken_q;
  assign bus.Illegal     = illegal_q;

endmodule

// File: tb/tb_execute_unit_pipe.sv
// Self-checking bench for execute_unit_pipe: directed literal cases plus randomized traffic
// compared every cycle against a behavioural model of the unit.
module tb_execute_unit_pipe;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  execute_unit_pipe_if #(.XLEN(XLEN)) bus();

  execute_unit_pipe #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  alu_op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        src;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic [63:0] pc;
  } op_t;

  typedef struct packed {
    logic [63:0] result;
    logic [63:0] target;
    logic        zero;
    logic        taken;
    logic        illegal;
    logic        is_mul;
  } res_t;

  int   tests_run    = 0;
  int   tests_failed = 0;
  bit   check_en     = 1'b0;
  bit   m_valid      = 1'b0;
  int   m_mul_left   = 0;
  res_t m_out        = '0;
  res_t m_mul_out    = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic op_t mkOp(input logic [1:0] alu_op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic src, input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] c, input logic [63:0] pc);
    op_t o;
    o.alu_op = alu_op; o.f3 = f3; o.f7 = f7; o.src = src;
    o.a = a; o.b = b; o.c = c; o.pc = pc;
    return o;
  endfunction

  // What the unit must produce for one operation, straight from the RV semantics
  function automatic res_t refModel(input op_t op);
    res_t        r;
    logic [63:0] o2;
    longint      sa, sb;
    int          sh;
    bit          legal;
    r     = '0;
    legal = 1'b1;
    o2    = op.src ? op.c : op.b;
    sa    = op.a;
    sb    = o2;
    sh    = int'(o2 % 64);
    r.target = op.pc + op.c * 2;
    if (op.alu_op == 2'b00) begin
      r.result = op.a + o2;
    end else if (op.alu_op == 2'b01) begin
      r.result = op.a - o2;
      case (op.f3)
        3'd0: r.taken = (op.a == o2);
        3'd1: r.taken = (op.a != o2);
        3'd4: r.taken = (sa < sb);
        3'd5: r.taken = (sa >= sb);
        3'd6: r.taken = (op.a < o2);
        3'd7: r.taken = (op.a >= o2);
        default: r.illegal = 1'b1;
      endcase
    end else begin
      if (op.alu_op == 2'b10) begin
        if (op.f7 == 7'd1) begin
`ifdef EXEC_MUL_EN
          if (op.f3 == 3'd0) r.is_mul = 1'b1;
          else               legal = 1'b0;
`else
          legal = 1'b0;
`endif
        end else if (op.f7 != 7'd0 && !(op.f7 == 7'h20 && (op.f3 == 3'd0 || op.f3 == 3'd5))) begin
          legal = 1'b0;
        end
      end
      if (r.is_mul) r.result = op.a * o2;
      else if (!legal) r.illegal = 1'b1;
      else begin
        case (op.f3)
          3'd0: r.result = (op.alu_op == 2'b10 && op.f7 == 7'h20) ? op.a - o2 : op.a + o2;
          3'd1: r.result = op.a << sh;
          3'd2: r.result = (sa < sb) ? 64'd1 : 64'd0;
          3'd3: r.result = (op.a < o2) ? 64'd1 : 64'd0;
          3'd4: r.result = op.a ^ o2;
          3'd5: begin
            if (op.f7[5]) r.result = sa >>> sh;
            else          r.result = op.a >> sh;
          end
          3'd6: r.result = op.a | o2;
          default: r.result = op.a & o2;
        endcase
      end
    end
    r.zero = (r.result == 64'd0);
    return r;
  endfunction

  // Drive one cycle of inputs, advance the model across the rising edge, return at the next falling edge
  task automatic applyStimulus(input bit v, input op_t op, input bit ordy, input bit fl, input bit rst);
    bit   ready;
    res_t calc;
    bus.in_valid  = v;
    bus.ALUOp     = op.alu_op;
    bus.funct3    = op.f3;
    bus.funct7    = op.f7;
    bus.ALUSrc    = op.src;
    bus.A         = op.a;
    bus.B         = op.b;
    bus.C         = op.c;
    bus.PC        = op.pc;
    bus.out_ready = ordy;
    flush         = fl;
    reset         = rst;
    #1;
    ready = (m_mul_left == 0) && (!m_valid || ordy);
    if (check_en) checkOutput("in_ready", bus.in_ready, ready);
    calc = refModel(op);
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_mul_left = 0; m_out = '0;
    end else if (fl) begin
      m_valid = 1'b0; m_mul_left = 0;
    end else if (m_mul_left > 0) begin
      m_mul_left--;
      if (m_mul_left == 0) begin m_valid = 1'b1; m_out = m_mul_out; end
    end else if (v && ready) begin
      if (calc.is_mul) begin m_valid = 1'b0; m_mul_left = XLEN; m_mul_out = calc; end
      else             begin m_valid = 1'b1; m_out = calc; end
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("out_valid", bus.out_valid, m_valid);
      if (m_valid) begin
        checkOutput("ALU_result",  bus.ALU_result,  m_out.result);
        checkOutput("Target",      bus.Target,      m_out.target);
        checkOutput("Zero",        bus.Zero,        m_out.zero);
        checkOutput("BranchTaken", bus.BranchTaken, m_out.taken);
        checkOutput("Illegal",     bus.Illegal,     m_out.illegal);
      end
    end
  end

  function automatic logic [63:0] pickVal();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return '1;
      3:       return 64'h8000_0000_0000_0000;
      4:       return 64'($urandom_range(0, 70));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  function automatic op_t randOp();
    op_t o;
    int  r;
    o.alu_op = 2'($urandom_range(0, 3));
    o.f3     = 3'($urandom_range(0, 7));
    r        = $urandom_range(0, 9);
    if (r <= 5)      o.f7 = 7'h00;
    else if (r <= 7) o.f7 = 7'h20;
    else if (r == 8) o.f7 = 7'h01;
    else             o.f7 = 7'($urandom());
    o.src = 1'($urandom_range(0, 1));
    o.a   = pickVal();
    o.b   = pickVal();
    o.c   = pickVal();
    o.pc  = {$urandom(), $urandom()};
    return o;
  endfunction

  initial begin
    op_t nop;
    bit  seen;
    nop = mkOp(2'b00, 3'd0, 7'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0);
    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, nop, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, nop, 1'b1, 1'b0, 1'b1);
    check_en = 1'b1;

    checkOutput("rst_out_valid",   bus.out_valid,   64'd0);
    checkOutput("rst_ALU_result",  bus.ALU_result,  64'd0);
    checkOutput("rst_Zero",        bus.Zero,        64'd0);

    // sub, latency 1
    applyStimulus(1'b1, mkOp(2'b10, 3'd0, 7'h20, 1'b0, 64'd5, 64'd7, 64'd0, 64'd0), 1'b0, 1'b0, 1'b0);
    checkOutput("sub_out_valid", bus.out_valid,  64'd1);
    checkOutput("sub_result",    bus.ALU_result, 64'hFFFF_FFFF_FFFF_FFFE);
    checkOutput("sub_zero",      bus.Zero,       64'd0);

    // backpressure then a back-to-back stream
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, mkOp(2'b00, 3'd0, 7'd0, 1'b0, 64'd9, 64'd9, 64'd0, 64'd0), 1'b0, 1'b0, 1'b0);
      checkOutput("bp_hold_result", bus.ALU_result, 64'hFFFF_FFFF_FFFF_FFFE);
      checkOutput("bp_in_ready",    bus.in_ready,   64'd0);
    end
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, mkOp(2'b00, 3'd0, 7'd0, 1'b1, 64'(i), 64'd0, 64'd100, 64'd0), 1'b1, 1'b0, 1'b0);
      checkOutput("stream_result", bus.ALU_result, 64'(100 + i));
    end
    applyStimulus(1'b0, nop, 1'b1, 1'b0, 1'b0);

    // branches
    applyStimulus(1'b1, mkOp(2'b01, 3'd4, 7'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 64'h10, 64'h1000),
                  1'b1, 1'b0, 1'b0);
    checkOutput("blt_taken",  bus.BranchTaken, 64'd1);
    checkOutput("blt_target", bus.Target,      64'h1020);
    applyStimulus(1'b1, mkOp(2'b01, 3'd6, 7'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 64'h10, 64'h1000),
                  1'b1, 1'b0, 1'b0);
    checkOutput("bltu_taken", bus.BranchTaken, 64'd0);
    applyStimulus(1'b1, mkOp(2'b01, 3'd2, 7'd0, 1'b0, 64'd4, 64'd4, 64'd0, 64'd0), 1'b1, 1'b0, 1'b0);
    checkOutput("br010_illegal", bus.Illegal, 64'd1);

    // shifts
    applyStimulus(1'b1, mkOp(2'b11, 3'd5, 7'h20, 1'b1, 64'h8000_0000_0000_0000, 64'd0, 64'd4, 64'd0),
                  1'b1, 1'b0, 1'b0);
    checkOutput("srai_result", bus.ALU_result, 64'hF800_0000_0000_0000);
    applyStimulus(1'b1, mkOp(2'b11, 3'd1, 7'h00, 1'b1, 64'h8000_0000_0000_0000, 64'd0, 64'd64, 64'd0),
                  1'b1, 1'b0, 1'b0);
    checkOutput("slli64_result", bus.ALU_result, 64'h8000_0000_0000_0000);

    // illegal R-type funct7
    applyStimulus(1'b1, mkOp(2'b10, 3'd0, 7'h40, 1'b0, 64'd3, 64'd3, 64'd0, 64'd0), 1'b1, 1'b0, 1'b0);
    checkOutput("badf7_illegal", bus.Illegal,    64'd1);
    checkOutput("badf7_result",  bus.ALU_result, 64'd0);
    checkOutput("badf7_zero",    bus.Zero,       64'd1);
    applyStimulus(1'b0, nop, 1'b1, 1'b0, 1'b0);

    // flush while a result is presented drops it and the offered op
    applyStimulus(1'b1, mkOp(2'b00, 3'd0, 7'd0, 1'b0, 64'd1, 64'd1, 64'd0, 64'd0), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, mkOp(2'b00, 3'd0, 7'd0, 1'b0, 64'd50, 64'd0, 64'd0, 64'd0), 1'b1, 1'b1, 1'b0);
    checkOutput("flush_out_valid", bus.out_valid, 64'd0);
    applyStimulus(1'b0, nop, 1'b1, 1'b0, 1'b0);
    checkOutput("flush_dropped", bus.out_valid, 64'd0);

    // reset while FULL
    applyStimulus(1'b1, mkOp(2'b01, 3'd0, 7'd0, 1'b0, 64'd7, 64'd7, 64'd8, 64'h40), 1'b0, 1'b0, 1'b0);
    checkOutput("beq_target", bus.Target, 64'h50);
    applyStimulus(1'b0, nop, 1'b0, 1'b0, 1'b1);
    checkOutput("rstfull_out_valid", bus.out_valid,   64'd0);
    checkOutput("rstfull_result",    bus.ALU_result,  64'd0);
    checkOutput("rstfull_target",    bus.Target,      64'd0);
    checkOutput("rstfull_zero",      bus.Zero,        64'd0);
    checkOutput("rstfull_taken",     bus.BranchTaken, 64'd0);
    checkOutput("rstfull_illegal",   bus.Illegal,     64'd0);

`ifdef EXEC_MUL_EN
    applyStimulus(1'b1, mkOp(2'b10, 3'd0, 7'h01, 1'b0, 64'h1_0000_0001, 64'd3, 64'd0, 64'd0),
                  1'b1, 1'b0, 1'b0);
    for (int i = 0; i < XLEN; i++) begin
      applyStimulus(1'b0, nop, 1'b1, 1'b0, 1'b0);
      if (i == 10) checkOutput("mul_in_ready", bus.in_ready, 64'd0);
    end
    checkOutput("mul_out_valid", bus.out_valid,  64'd1);
    checkOutput("mul_result",    bus.ALU_result, 64'h3_0000_0003);
    applyStimulus(1'b0, nop, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, mkOp(2'b10, 3'd0, 7'h01, 1'b0, 64'd6, 64'd7, 64'd0, 64'd0), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, nop, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, nop, 1'b1, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < XLEN + 6; i++) begin
      applyStimulus(1'b0, nop, 1'b1, 1'b0, 1'b0);
      seen = seen | bus.out_valid;
    end
    checkOutput("mulflush_no_result", seen, 64'd0);
`else
    applyStimulus(1'b1, mkOp(2'b10, 3'd0, 7'h01, 1'b0, 64'd6, 64'd7, 64'd0, 64'd0), 1'b1, 1'b0, 1'b0);
    checkOutput("nomul_out_valid", bus.out_valid,  64'd1);
    checkOutput("nomul_illegal",   bus.Illegal,    64'd1);
    checkOutput("nomul_result",    bus.ALU_result, 64'd0);
`endif
    applyStimulus(1'b0, nop, 1'b1, 1'b0, 1'b0);

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, randOp(), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0);
    end

    #2;
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
